run_ctrl: RTL and testbench
===========================

Name: run_ctrl

Overview:
- Sequences the rng -> divide_by_three -> sum_3 -> counter datapath from a single start/stop push-button.
- Replaces the key-edge-clocked run/stop toggle with a synchronised, debounced, fully clk-domain FSM.
- Drives the datapath enables (run), the display freeze (stop) and a one-cycle seed/clear pulse; sits between the board KEY input and the datapath in top.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a button level change (20 ms at 50 MHz); must be >= 2.
- DB_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES-1.
- MAX_RUN_CYCLES, 50000000, auto-stop limit in cycles (used only with RUN_CTRL_AUTO_STOP_EN).
- RUN_W, 26, run-length counter width; must hold MAX_RUN_CYCLES-1.

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst  in  1  asynchronous, active-high reset
- start_n  in  1  raw button, active-low (KEY[3]), asynchronous to clk
- run  out  1  datapath enable; connects to the en input of rng, sum_3 and counter
- stop  out  1  display freeze; connects to counter.stop
- seed  out  1  one-cycle pulse on IDLE->RUN only
- state  out  2  00 IDLE, 01 RUN, 10 HALT; 11 is unused
- timed_out  out  1  sticky auto-stop flag

Behaviour:
- Reset: asynchronous, active-high, one clock. While rst=1: sync flops = 1, debounced level = 1 (released), debounce counter = 0, press = 0, state = IDLE, run = 0, stop = 0, seed = 0, timed_out = 0, run counter = 0.
- Synchroniser: 2-flop on start_n.
- Debounce: the counter increments every cycle the synced level differs from the debounced level, and clears on any cycle they match.
  - The debounced level flips, and the counter clears, at the edge where a mismatch occurs with the counter at DEBOUNCE_CYCLES-1.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
- press: registered one-cycle pulse on a debounced 1->0 transition only; release never generates a press.
- FSM (run, stop, seed are registered outputs decoded from state):
  - IDLE: run=0, stop=0. press -> RUN, with seed=1 for exactly the first RUN cycle.
  - RUN: run=1, stop=0. press -> HALT.
  - HALT: run=0, stop=1. press -> RUN, with no seed pulse.
- Latency: number the first edge sampling start_n=0 as edge 1, with the button held low throughout.
  - Debounced level flips at edge DEBOUNCE_CYCLES+2.
  - press is high after edge DEBOUNCE_CYCLES+3.
  - State and run change at edge DEBOUNCE_CYCLES+4.
- Holding the button: produces exactly one press. A new press requires a debounced release followed by a debounced press.
- Reset mid-debounce or mid-RUN: returns immediately to IDLE; no press is generated by a button still held when rst deasserts, because the debounced level restarts at released and the held low is then accepted once, after DEBOUNCE_CYCLES+4 edges.
- Illegal state 11: next edge -> IDLE.

Optional Feature:
- Macro RUN_CTRL_AUTO_STOP_EN defined:
  - The run counter clears on every entry to RUN and increments each RUN cycle.
  - At the edge where the counter is MAX_RUN_CYCLES-1, the FSM goes RUN->HALT and sets timed_out=1.
  - timed_out clears on the next entry to RUN or on rst.
  - A press in that same cycle also goes to HALT, and timed_out still sets.
- Macro undefined: no run counter; timed_out is tied to 0; RUN is left only by press or rst.

Test Plan (DEBOUNCE_CYCLES=4, MAX_RUN_CYCLES=10):
- Hold start_n=0 from edge 1 -> press high after edge 7; run=1 and seed=1 after edge 8; seed=0 after edge 9; run stays 1 while held, with no second press.
- start_n low for 3 cycles, then high -> debounced level never flips; state stays IDLE; run=0.
- Sequence press, release, press (each held >= 8 cycles), from IDLE -> RUN, then HALT (stop=1, run=0); a third press -> RUN with seed staying 0.
- In RUN with start_n held low, assert rst for 1 cycle -> outputs 0 and state IDLE immediately; run=1 again 8 edges after rst deasserts, with no extra press.
- With RUN_CTRL_AUTO_STOP_EN and no button activity after entering RUN -> HALT and timed_out=1 after 10 RUN cycles; the next press -> RUN with timed_out=0.
- Without the macro -> RUN persists 1000 cycles; timed_out=0 throughout.

Source files
------------

// File: rtl/run_ctrl_if.sv
// run_ctrl_if: groups the push-button input and the datapath control
// outputs of run_ctrl. The master side is the controller itself; the
// slave side is whatever consumes run/stop/seed (datapath or bench).
// The button is a plain level input with no handshake. The outputs are
// registered levels and pulses that are valid every cycle after reset.
interface run_ctrl_if;
  logic       start_n;
  logic       run;
  logic       stop;
  logic       seed;
  logic [1:0] state;
  logic       timed_out;

  modport master (
    input  start_n,
    output run,
    output stop,
    output seed,
    output state,
    output timed_out
  );

  modport slave (
    output start_n,
    input  run,
    input  stop,
    input  seed,
    input  state,
    input  timed_out
  );
endinterface

// File: rtl/run_ctrl.sv
// run_ctrl: start/stop sequencer for the rng -> divide_by_three -> sum_3 ->
// counter datapath. A raw active-low push-button is synchronised and
// debounced, and turned into a one-cycle press pulse. That pulse steps an
// IDLE -> RUN -> HALT -> RUN ... FSM. Everything runs in the clk domain.
// Optional feature: define RUN_CTRL_AUTO_STOP_EN to leave RUN automatically
// after MAX_RUN_CYCLES cycles and raise the sticky timed_out flag.
module run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20,
  parameter int MAX_RUN_CYCLES  = 50000000,
  parameter int RUN_W           = 26
) (
  input logic        clk,
  input logic        rst,
  run_ctrl_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HALT = 2'b10;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync_1;
  logic            sync_2;
  logic            db_level;
  logic [DB_W-1:0] db_cnt;
  logic            db_prev;
  logic            press;

  logic [1:0]      state_q;
  logic [1:0]      state_next;
  logic            seed_next;
  logic            timeout_hit;
  logic            run_q;
  logic            stop_q;
  logic            seed_q;

  // Two-flop synchroniser; resets to the released (high) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= bus.start_n;
      sync_2 <= sync_1;
    end
  end

  // Debounce: count consecutive mismatching cycles. Accept the new level
  // on the mismatch that finds the counter already at DEBOUNCE_CYCLES-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_level <= 1'b1;
      db_cnt   <= '0;
    end else if (sync_2 != db_level) begin
      if (db_cnt == DB_LAST) begin
        db_level <= sync_2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Press pulse: one cycle after the debounced level falls. A rise never
  // produces a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_prev <= 1'b1;
      press   <= 1'b0;
    end else begin
      db_prev <= db_level;
      press   <= db_prev & ~db_level;
    end
  end

`ifdef RUN_CTRL_AUTO_STOP_EN
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_RUN_CYCLES - 1);

  logic [RUN_W-1:0] run_cnt;
  logic             timed_out_q;
  logic             enter_run;

  // A press from IDLE or HALT enters RUN. The illegal state ignores
  // presses and falls back to IDLE.
  assign enter_run   = press && ((state_q == S_IDLE) || (state_q == S_HALT));
  assign timeout_hit = (state_q == S_RUN) && (run_cnt == RUN_LAST);

  // Run-length counter and sticky timeout flag. Both are cleared on every
  // entry to RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt     <= '0;
      timed_out_q <= 1'b0;
    end else begin
      if (enter_run) begin
        run_cnt <= '0;
      end else if (state_q == S_RUN) begin
        run_cnt <= run_cnt + RUN_W'(1);
      end
      if (enter_run) begin
        timed_out_q <= 1'b0;
      end else if (timeout_hit) begin
        timed_out_q <= 1'b1;
      end
    end
  end

  assign bus.timed_out = timed_out_q;
`else
  // Without auto-stop, RUN is left only by a press or by reset.
  assign timeout_hit   = 1'b0;
  assign bus.timed_out = 1'b0;
`endif

  // Next-state logic. A press and a timeout in the same cycle both lead
  // to HALT.
  always_comb begin
    state_next = state_q;
    seed_next  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press) begin
          state_next = S_RUN;
          seed_next  = 1'b1;
        end
      end
      S_RUN: begin
        if (press || timeout_hit) begin
          state_next = S_HALT;
        end
      end
      S_HALT: begin
        if (press) begin
          state_next = S_RUN;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State and registered outputs are decoded from the next state, so
  // they change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      stop_q  <= 1'b0;
      seed_q  <= 1'b0;
    end else begin
      state_q <= state_next;
      run_q   <= (state_next == S_RUN);
      stop_q  <= (state_next == S_HALT);
      seed_q  <= seed_next;
    end
  end

  assign bus.run   = run_q;
  assign bus.stop  = stop_q;
  assign bus.seed  = seed_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: bench for run_ctrl with DEBOUNCE_CYCLES=4, MAX_RUN_CYCLES=10.
// A behavioural model tracks the button history, the debounced level, the
// press event and the run mode. The DUT outputs are compared against it
// every cycle. Directed checks pin the latencies and the reset behaviour.
// Build with +define+RUN_CTRL_AUTO_STOP_EN to cover the auto-stop feature.
module tb_run_ctrl;
  localparam int D   = 4;
  localparam int MAX = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  run_ctrl_if bus ();

  run_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .DB_W(3),
    .MAX_RUN_CYCLES(MAX),
    .RUN_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Mode: 0 idle, 1 running, 2 halted.
  bit hist0 = 1'b1, hist1 = 1'b1;   // button sampled one / two edges ago
  bit m_level = 1'b1;
  int m_streak = 0;
  bit m_fell = 1'b0, m_press = 1'b0, m_seed = 1'b0, m_to = 1'b0;
  int m_mode = 0, m_runlen = 0;

  always @(posedge clk) begin
    if (rst) begin
      hist0 = 1'b1; hist1 = 1'b1; m_level = 1'b1; m_streak = 0;
      m_fell = 1'b0; m_press = 1'b0; m_seed = 1'b0; m_to = 1'b0;
      m_mode = 0; m_runlen = 0;
    end else begin
      int old_mode;
      bit to_hit;
      bit visible;
      old_mode = m_mode;
      to_hit = 1'b0;
`ifdef RUN_CTRL_AUTO_STOP_EN
      to_hit = (old_mode == 1) && (m_runlen == MAX - 1);
`endif
      if (old_mode == 1) m_runlen++;
      m_seed = 1'b0;
      if (m_press && old_mode != 1) begin
        m_seed = (old_mode == 0);
        m_mode = 1;
        m_runlen = 0;
        m_to = 1'b0;
      end else if (old_mode == 1 && (m_press || to_hit)) begin
        m_mode = 2;
        if (to_hit) m_to = 1'b1;
      end
      m_press = m_fell;
      m_fell = 1'b0;
      visible = hist1;
      if (visible != m_level) begin
        m_streak++;
        if (m_streak == D) begin
          m_level = visible;
          m_streak = 0;
          m_fell = (visible == 1'b0);
        end
      end else begin
        m_streak = 0;
      end
      hist1 = hist0;
      hist0 = bus.start_n;
    end
    exp_q.push_back({m_mode == 1, m_mode == 2, m_seed, 2'(m_mode), m_to});
  end

  // Per-cycle scoreboard: compare the outputs against the model's value
  // for the most recent edge.
  always @(negedge clk) begin
    logic [5:0] exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_back();
      exp_q.delete();
      check("cycle", {26'd0, bus.run, bus.stop, bus.seed, bus.state, bus.timed_out}, {26'd0, exp});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic hold(input bit lvl, input int n);
    bus.start_n = lvl;
    tick(n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start_n = 1'b1;
    tick(2);
    check("reset_run", bus.run, 0);
    check("reset_state", bus.state, 0);
    check("reset_seed", bus.seed, 0);
    check("reset_timed_out", bus.timed_out, 0);
    rst = 1'b0;
    tick(3);

    // Hold from edge 1: the press lands after edge 7 and RUN after edge 8.
    bus.start_n = 1'b0;
    tick(7);
    check("lat_run_e7", bus.run, 0);
    tick(1);
    check("lat_run_e8", bus.run, 1);
    check("lat_seed_e8", bus.seed, 1);
    check("lat_state_e8", bus.state, 1);
    tick(1);
    check("lat_seed_e9", bus.seed, 0);
`ifndef RUN_CTRL_AUTO_STOP_EN
    tick(20);
    check("hold_run", bus.run, 1);
    check("hold_state", bus.state, 1);
`endif
    hold(1'b1, 10);

    // A short glitch must never be accepted.
    do_reset();
    hold(1'b0, 3);
    hold(1'b1, 15);
    check("glitch_state", bus.state, 0);
    check("glitch_run", bus.run, 0);

    // Press / release / press / release / press.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      hold(1'b0, 9);
      hold(1'b1, 9);
    end

    // Reset while running with the button held low.
    do_reset();
    hold(1'b0, 12);
    rst = 1'b1;
    #1;
    check("rst_run_now", bus.run, 0);
    check("rst_state_now", bus.state, 0);
    tick(1);
    rst = 1'b0;
    tick(7);
    check("rst_run_e7", bus.run, 0);
    tick(1);
    check("rst_run_e8", bus.run, 1);
    hold(1'b1, 10);

`ifdef RUN_CTRL_AUTO_STOP_EN
    // Auto-stop: RUN is entered at edge 8, HALT follows 10 RUN cycles later.
    do_reset();
    hold(1'b0, 8);
    check("auto_enter", bus.state, 1);
    hold(1'b1, 10);
    check("auto_state", bus.state, 2);
    check("auto_timed_out", bus.timed_out, 1);
    check("auto_stop", bus.stop, 1);
    hold(1'b0, 8);
    check("auto_rerun", bus.state, 1);
    check("auto_to_clear", bus.timed_out, 0);
    hold(1'b1, 10);
`else
    // Without auto-stop, RUN persists.
    do_reset();
    hold(1'b0, 8);
    hold(1'b1, 1000);
    check("persist_state", bus.state, 1);
    check("persist_to", bus.timed_out, 0);
`endif

    // Random button activity with occasional resets.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 30) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 14));
    end

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
